vram_stream_ctrl: RTL and testbench

- Sequences the pixel stream from the host/network side into the dual-bank VRAM write port of the vga block.
- Buffers incoming RGB pixels in a small FIFO and issues one vram_req per pixel while vram_ready is high.
- Drives vram_reset and vram_active around frame boundaries, preloads the VRAM before display switches to VRAM output, and counts pixels against H*V.
- Reports frame completion, aborts and underruns to the command/status logic.

---
 rtl/vram_pkg.sv | 18 +
 rtl/vram_stream_ctrl_if.sv | 30 +++
 rtl/pix_fifo.sv | 65 ++++++
 rtl/vram_stream_ctrl.sv | 161 ++++++++++++++++
 tb/tb_vram_stream_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_pkg.sv
// Shared types and defaults for the VRAM stream controller.
//   PIX_W / CNT_W : pixel and pixel-counter widths
//   state_t       : controller FSM states
package vram_pkg;

  localparam int unsigned PIX_W          = 24;
  localparam int unsigned CNT_W          = 24;
  localparam int unsigned PRELOAD_DEF    = 81;
  localparam int unsigned RST_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RST    = 2'd1,
    FILL   = 2'd2,
    STREAM = 2'd3
  } state_t;

endpackage

// File: rtl/vram_stream_ctrl_if.sv
// Pixel-stream input and VRAM write-port signals of the stream controller.
//   master : controller view (accepts pixels, drives the VRAM write port)
//   slave  : host/vga view (sources pixels, consumes the VRAM write port)
interface vram_stream_ctrl_if;
  import vram_pkg::*;

  logic             pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic             pix_ready;
  logic             vram_ready;
  logic             vram_synced;
  logic             vram_req;
  logic [7:0]       r_vram_out;
  logic [7:0]       g_vram_out;
  logic [7:0]       b_vram_out;
  logic             vram_reset;
  logic             vram_active;

  modport master (
    input  pix_valid, pix_data, vram_ready, vram_synced,
    output pix_ready, vram_req, r_vram_out, g_vram_out, b_vram_out,
           vram_reset, vram_active
  );

  modport slave (
    output pix_valid, pix_data, vram_ready, vram_synced,
    input  pix_ready, vram_req, r_vram_out, g_vram_out, b_vram_out,
           vram_reset, vram_active
  );
endinterface

// File: rtl/pix_fifo.sv
// Synchronous pixel FIFO; head word is registered into dout on pop.
//   clk, rst_n : clock, async active-low reset
//   flush      : empty the FIFO (a same-cycle pop still updates dout)
//   push, din  : write side
//   pop, dout  : read side, dout valid the cycle after pop
//   full, empty: status flags
module pix_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_pop) dout <= mem[rd_ptr];
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({do_push, do_pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end
endmodule

// File: rtl/vram_stream_ctrl.sv
// Sequences a host pixel stream into the vga dual-bank VRAM write port.
//   clk_sys, reset_n         : clock, async active-low reset
//   H, V                     : frame geometry, sampled on frame_start
//   frame_start/resync/stop  : frame control pulses
//   bus (master)             : pixel input handshake and VRAM write port
//   frame_done, pix_written  : progress of the current frame
//   underrun, bad_geom       : sticky errors, cleared by an accepted start
//   abort_cnt                : saturating count of aborted frames
module vram_stream_ctrl
  import vram_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PRELOAD    = PRELOAD_DEF,
  parameter int unsigned RST_CYCLES = RST_CYCLES_DEF
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic [15:0]      H,
  input  logic [15:0]      V,
  input  logic             frame_start,
  input  logic             frame_resync,
  input  logic             stream_stop,
  vram_stream_ctrl_if.master bus,
  output logic             frame_done,
  output logic [CNT_W-1:0] pix_written,
  output logic             underrun,
  output logic             bad_geom,
  output logic [7:0]       abort_cnt
);
  localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);

  state_t           state;
  logic [CNT_W-1:0] total;
  logic [RST_W-1:0] rst_cnt;
  logic             vram_req_q;
  logic             vram_reset_q;
  logic             vram_active_q;

  logic [PIX_W-1:0] head;
  logic             fifo_full;
  logic             fifo_empty;

  logic [CNT_W-1:0] total_c;
  logic [CNT_W-1:0] preload_tgt_c;
  logic             writing_c;
  logic             push_c;
  logic             pop_c;
  logic             last_c;
  logic             start_c;
  logic             to_rst_c;
  logic             flush_c;

  // Issue and transition decode from the current registers.
  always_comb begin
    total_c       = CNT_W'(H) * CNT_W'(V);
    preload_tgt_c = (total < CNT_W'(PRELOAD)) ? total : CNT_W'(PRELOAD);
    writing_c     = (state == FILL) || (state == STREAM);
    push_c        = bus.pix_valid && !fifo_full && writing_c;
    pop_c         = writing_c && !fifo_empty && bus.vram_ready &&
                    (pix_written < total) && !stream_stop;
    last_c        = pop_c && ((pix_written + CNT_W'(1)) == total);
    start_c       = frame_start && !stream_stop && (total_c != '0);
    to_rst_c      = frame_resync || !vram_active_q;
    // FIFO is emptied whenever the next state is RST or IDLE.
    flush_c       = stream_stop || (start_c && to_rst_c) || (last_c && !start_c);
  end

  pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PIX_W)
  ) u_fifo (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .flush (flush_c),
    .push  (push_c),
    .din   (bus.pix_data),
    .pop   (pop_c),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Controller FSM with registered outputs; later statements take priority.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      total         <= '0;
      pix_written   <= '0;
      rst_cnt       <= '0;
      vram_req_q    <= 1'b0;
      vram_reset_q  <= 1'b0;
      vram_active_q <= 1'b0;
      frame_done    <= 1'b0;
      underrun      <= 1'b0;
      bad_geom      <= 1'b0;
      abort_cnt     <= '0;
    end else begin
      vram_req_q <= pop_c;
      frame_done <= last_c;
      if (pop_c) pix_written <= pix_written + CNT_W'(1);

      case (state)
        RST: begin
          if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
            vram_reset_q <= 1'b0;
            state        <= FILL;
          end else begin
            rst_cnt <= rst_cnt + RST_W'(1);
          end
        end
        FILL: begin
          if (pop_c && ((pix_written + CNT_W'(1)) == preload_tgt_c)) begin
            vram_active_q <= 1'b1;
            state         <= last_c ? IDLE : STREAM;
          end
        end
        STREAM: begin
          if (vram_active_q && !bus.vram_synced) underrun <= 1'b1;
          if (last_c) state <= IDLE;
        end
        default: ;
      endcase

      // A completing write in the start cycle is not an abort.
      if (frame_start && !stream_stop) begin
        if (!start_c) begin
          bad_geom <= 1'b1;
        end else begin
          underrun    <= 1'b0;
          bad_geom    <= 1'b0;
          pix_written <= '0;
          total       <= total_c;
          if (writing_c && !last_c && (abort_cnt != 8'hFF))
            abort_cnt <= abort_cnt + 8'd1;
          if (to_rst_c) begin
            state         <= RST;
            rst_cnt       <= '0;
            vram_reset_q  <= 1'b1;
            vram_active_q <= 1'b0;
          end else begin
            state <= STREAM;
          end
        end
      end

      if (stream_stop) begin
        state         <= IDLE;
        vram_active_q <= 1'b0;
        vram_reset_q  <= 1'b0;
      end
    end
  end

  assign bus.pix_ready   = !fifo_full && writing_c;
  assign bus.vram_req    = vram_req_q;
  assign bus.vram_reset  = vram_reset_q;
  assign bus.vram_active = vram_active_q;
  assign bus.r_vram_out  = head[23:16];
  assign bus.g_vram_out  = head[15:8];
  assign bus.b_vram_out  = head[7:0];
endmodule

// File: tb/tb_vram_stream_ctrl.sv
// Self-checking bench for vram_stream_ctrl: scoreboard of accepted pixels
// compared against VRAM writes, plus frame-control and error scenarios.
module tb_vram_stream_ctrl;
  localparam int TOT = 1200;   // 40 x 30 frame

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [15:0] H, V;
  logic        frame_start, frame_resync, stream_stop;
  logic        frame_done, underrun, bad_geom;
  logic [23:0] pix_written;
  logic [7:0]  abort_cnt;

  vram_stream_ctrl_if bus();

  vram_stream_ctrl dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .H            (H),
    .V            (V),
    .frame_start  (frame_start),
    .frame_resync (frame_resync),
    .stream_stop  (stream_stop),
    .bus          (bus),
    .frame_done   (frame_done),
    .pix_written  (pix_written),
    .underrun     (underrun),
    .bad_geom     (bad_geom),
    .abort_cnt    (abort_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  int          errors = 0;
  int          checks = 0;
  logic [23:0] exp_q[$];
  int          req_cnt, done_cnt, rst_hi, act_low, act_rise_pw;
  int          src_cnt, src_lim;
  bit          src_en;
  logic        prev_rdy;
  logic        act_prev;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock: record acceptance, advance, monitor outputs, drive next pixel.
  task automatic step();
    logic acc;
    acc = bus.pix_valid && bus.pix_ready;
    if (acc) begin
      exp_q.push_back(bus.pix_data);
      src_cnt++;
    end
    prev_rdy = bus.vram_ready;
    @(posedge clk_sys);
    #1;
    if (bus.vram_req) begin
      req_cnt++;
      check_eq("req_while_not_ready", 32'(prev_rdy), 32'd1);
      if (exp_q.size() == 0) check_eq("sb_underflow", 32'd1, 32'd0);
      else check_eq("pix_data", 32'({bus.r_vram_out, bus.g_vram_out, bus.b_vram_out}),
                    32'(exp_q.pop_front()));
    end
    if (bus.vram_reset) rst_hi++;
    if (!bus.vram_active) act_low++;
    if (frame_done) done_cnt++;
    if (bus.vram_active && !act_prev) act_rise_pw = int'(pix_written);
    act_prev = bus.vram_active;
    if (acc || !bus.pix_valid) begin
      if (src_en && (src_cnt < src_lim)) begin
        bus.pix_valid = 1'b1;
        bus.pix_data  = 24'($urandom);
      end else begin
        bus.pix_valid = 1'b0;
      end
    end
  endtask

  task automatic clear_counts();
    req_cnt = 0; done_cnt = 0; rst_hi = 0; act_low = 0; act_rise_pw = -1;
  endtask

  task automatic start_frame(input logic [15:0] h, input logic [15:0] v, input logic resync);
    H = h; V = v; frame_resync = resync;
    bus.pix_valid = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic run_to_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    if (done_cnt == 0) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_until_pw(input int target, input int budget);
    int n;
    n = 0;
    while (int'(pix_written) < target && n < budget) begin
      step();
      n++;
    end
    if (int'(pix_written) < target) check_eq("pw_timeout", 32'(pix_written), 32'(target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit stalled;
    int n, rq0;
    reset_n = 1'b0; H = '0; V = '0;
    frame_start = 1'b0; frame_resync = 1'b0; stream_stop = 1'b0;
    bus.pix_valid = 1'b0; bus.pix_data = '0;
    bus.vram_ready = 1'b1; bus.vram_synced = 1'b1;
    src_en = 1'b0; src_cnt = 0; src_lim = 0; act_prev = 1'b0; prev_rdy = 1'b1;
    clear_counts();
    repeat (3) @(posedge clk_sys);
    #1;
    check_eq("rst_pix_ready", 32'(bus.pix_ready), 32'd0);
    check_eq("rst_vram_req", 32'(bus.vram_req), 32'd0);
    check_eq("rst_vram_active", 32'(bus.vram_active), 32'd0);
    check_eq("rst_pix_written", 32'(pix_written), 32'd0);
    check_eq("rst_flags", 32'({frame_done, underrun, bad_geom, bus.vram_reset}), 32'd0);
    reset_n = 1'b1;
    step();

    // Cold start with VRAM reset and preload.
    src_en = 1'b1; src_cnt = 0; src_lim = TOT; clear_counts();
    start_frame(16'd40, 16'd30, 1'b1);
    run_to_done(5000);
    repeat (4) step();
    check_eq("cold_rst_cycles", 32'(rst_hi), 32'd2);
    check_eq("cold_act_at", 32'(act_rise_pw), 32'd81);
    check_eq("cold_reqs", 32'(req_cnt), 32'(TOT));
    check_eq("cold_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("cold_pix_written", 32'(pix_written), 32'(TOT));
    check_eq("cold_active_held", 32'(bus.vram_active), 32'd1);
    check_eq("cold_sb_left", 32'(exp_q.size()), 32'd0);

    // Continuous frame with a backpressure stall mid-frame.
    src_cnt = 0; clear_counts();
    start_frame(16'd40, 16'd30, 1'b0);
    stalled = 1'b0; n = 0;
    while (done_cnt == 0 && n < 5000) begin
      if (!stalled && int'(pix_written) >= 400) begin
        stalled = 1'b1;
        bus.vram_ready = 1'b0;
        repeat (20) step();
        check_eq("bp_pix_ready", 32'(bus.pix_ready), 32'd0);
        check_eq("bp_fifo_fill", 32'(exp_q.size()), 32'd16);
        bus.vram_ready = 1'b1;
      end
      step();
      n++;
    end
    if (done_cnt == 0) check_eq("cont_timeout", 32'd0, 32'd1);
    repeat (4) step();
    check_eq("cont_no_reset", 32'(rst_hi), 32'd0);
    check_eq("cont_active_low", 32'(act_low), 32'd0);
    check_eq("cont_reqs", 32'(req_cnt), 32'(TOT));
    check_eq("cont_done_cnt", 32'(done_cnt), 32'd1);

    // Zero geometry is rejected without a state change.
    start_frame(16'd0, 16'd30, 1'b1);
    step();
    check_eq("geom_bad", 32'(bad_geom), 32'd1);
    check_eq("geom_no_reset", 32'(bus.vram_reset), 32'd0);
    check_eq("geom_pw_held", 32'(pix_written), 32'(TOT));
    check_eq("geom_idle", 32'(bus.pix_ready), 32'd0);

    // Underrun during STREAM, then abort at pixel 1000 with resync.
    src_cnt = 0; clear_counts();
    start_frame(16'd40, 16'd30, 1'b0);
    check_eq("geom_cleared", 32'(bad_geom), 32'd0);
    run_until_pw(200, 2000);
    bus.vram_synced = 1'b0;
    step();
    bus.vram_synced = 1'b1;
    step();
    check_eq("underrun_set", 32'(underrun), 32'd1);
    n = 0;
    while (int'(pix_written) != 1000 && n < 2000) begin
      step();
      n++;
    end
    check_eq("abort_pw_reached", 32'(pix_written), 32'd1000);
    src_en = 1'b0; bus.vram_ready = 1'b0; clear_counts();
    start_frame(16'd40, 16'd30, 1'b1);
    exp_q.delete();
    check_eq("abort_cnt", 32'(abort_cnt), 32'd1);
    check_eq("abort_pw_zero", 32'(pix_written), 32'd0);
    check_eq("abort_rst", 32'(bus.vram_reset), 32'd1);
    check_eq("abort_underrun_clr", 32'(underrun), 32'd0);
    bus.vram_ready = 1'b1; src_en = 1'b1; src_cnt = 0; src_lim = TOT;
    run_to_done(5000);
    repeat (4) step();
    check_eq("abort_new_reqs", 32'(req_cnt), 32'(TOT));
    check_eq("abort_new_rst", 32'(rst_hi), 32'd2);
    check_eq("abort_new_act_at", 32'(act_rise_pw), 32'd81);

    // Asynchronous reset mid-FILL.
    src_cnt = 0; clear_counts();
    start_frame(16'd40, 16'd30, 1'b1);
    run_until_pw(10, 100);
    reset_n = 1'b0;
    #1;
    check_eq("arst_pix_written", 32'(pix_written), 32'd0);
    check_eq("arst_abort_cnt", 32'(abort_cnt), 32'd0);
    check_eq("arst_outputs", 32'({bus.vram_req, bus.vram_reset, bus.vram_active,
                                  bus.pix_ready, frame_done}), 32'd0);
    check_eq("arst_data", 32'({bus.r_vram_out, bus.g_vram_out, bus.b_vram_out}), 32'd0);
    src_en = 1'b0; bus.pix_valid = 1'b0; exp_q.delete(); act_prev = 1'b0;
    #2;
    reset_n = 1'b1;
    step();

    // stream_stop wins over a same-cycle frame_start.
    src_en = 1'b1; src_cnt = 0; clear_counts();
    start_frame(16'd40, 16'd30, 1'b0);
    run_until_pw(300, 2000);
    check_eq("stop_pre_active", 32'(bus.vram_active), 32'd1);
    src_en = 1'b0; bus.pix_valid = 1'b0;
    frame_resync = 1'b1; stream_stop = 1'b1; frame_start = 1'b1;
    step();
    stream_stop = 1'b0; frame_start = 1'b0;
    rq0 = req_cnt;
    check_eq("stop_active", 32'(bus.vram_active), 32'd0);
    check_eq("stop_reset", 32'(bus.vram_reset), 32'd0);
    check_eq("stop_idle", 32'(bus.pix_ready), 32'd0);
    check_eq("stop_no_abort", 32'(abort_cnt), 32'd0);
    repeat (3) step();
    check_eq("stop_no_reqs", 32'(req_cnt), 32'(rq0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
